// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - ALU opcode/shift codes, FSM state encoding and unary-op helper for ula_cmd_driver
package ula_pkg;

  // ALU operation field, KEY[4:2]
  localparam logic [2:0] OP_PASSA = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_INC   = 3'b101;
  localparam logic [2:0] OP_DEC   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  // Post-shift field, KEY[1:0]
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_SL   = 2'b01;
  localparam logic [1:0] SH_SR   = 2'b10;
  localparam logic [1:0] SH_ZERO = 2'b11;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_EXEC = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Ops that only consume operand A; these skip the B beat.
  function automatic logic is_unary(input logic [2:0] op);
    return (op == OP_PASSA) || (op == OP_INC) || (op == OP_DEC);
  endfunction

endpackage

// File: rtl/ula_cmd_driver.sv
// rtl/ula_cmd_driver.sv - command front end for the 32-bit ULA; optional result chaining under ULA_CHAIN_EN
module ula_cmd_driver
  import ula_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [OPW-1:0]   in_op,
`ifdef ULA_CHAIN_EN
  input  logic             in_chain,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] SW1,
  output logic [WIDTH-1:0] SW2,
  output logic [OPW-1:0]   KEY,
  input  logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] res_data,
  output logic [OPW-1:0]   res_op,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] op_count
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sw1_q, sw1_d;
  logic [WIDTH-1:0]   sw2_q, sw2_d;
  logic [OPW-1:0]     key_q, key_d;
  logic [WIDTH-1:0]   res_data_q, res_data_d;
  logic [OPW-1:0]     res_op_q, res_op_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;
  logic [WIDTH-1:0]   a_src;

  // Operand A source: previous result when chaining, otherwise the beat data.
`ifdef ULA_CHAIN_EN
  assign a_src = in_chain ? res_data_q : in_data;
`else
  assign a_src = in_data;
`endif

  // Next-state and datapath updates; hold everything by default.
  always_comb begin
    state_d    = state_q;
    sw1_d      = sw1_q;
    sw2_d      = sw2_q;
    key_d      = key_q;
    res_data_d = res_data_q;
    res_op_d   = res_op_q;
    op_count_d = op_count_q;
    case (state_q)
      S_A: begin
        if (in_valid) begin
          sw1_d = a_src;
          key_d = in_op;
          if (is_unary(in_op[OPW-1:OPW-3])) begin
            sw2_d   = '0;
            state_d = S_EXEC;
          end else begin
            state_d = S_B;
          end
        end
      end
      S_B: begin
        if (in_valid) begin
          sw2_d   = in_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // ALU inputs have been stable for a full cycle; capture its result.
        res_data_d = alu_out;
        res_op_d   = key_q;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (res_ready) begin
          op_count_d = op_count_q + CNT_W'(1);
          state_d    = S_A;
        end
      end
      default: state_d = S_A;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_A;
      sw1_q      <= '0;
      sw2_q      <= '0;
      key_q      <= '0;
      res_data_q <= '0;
      res_op_q   <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      sw1_q      <= sw1_d;
      sw2_q      <= sw2_d;
      key_q      <= key_d;
      res_data_q <= res_data_d;
      res_op_q   <= res_op_d;
      op_count_q <= op_count_d;
    end
  end

  // Input and result phases never overlap: ready only while collecting operands.
  assign in_ready  = (state_q == S_A) || (state_q == S_B);
  assign res_valid = (state_q == S_RESP);
  assign SW1       = sw1_q;
  assign SW2       = sw2_q;
  assign KEY       = key_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_ula_cmd_driver.sv
// tb/tb_ula_cmd_driver.sv - directed self-checking bench for ula_cmd_driver (covers ULA_CHAIN_EN when defined)
module tb_ula_cmd_driver;
  import ula_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [4:0]  in_op;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] sw1, sw2;
  logic [4:0]  key;
  logic [31:0] alu_out;
  logic [31:0] res_data;
  logic [4:0]  res_op;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] op_count;
`ifdef ULA_CHAIN_EN
  logic        in_chain;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ula_cmd_driver dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_op     (in_op),
`ifdef ULA_CHAIN_EN
    .in_chain  (in_chain),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SW1       (sw1),
    .SW2       (sw2),
    .KEY       (key),
    .alu_out   (alu_out),
    .res_data  (res_data),
    .res_op    (res_op),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .op_count  (op_count)
  );

  // Behavioural stand-in for the combinational ULA driven by SW1/SW2/KEY.
  logic [31:0] alu_pre;
  always_comb begin
    alu_pre = '0;
    case (key[4:2])
      OP_PASSA: alu_pre = sw1;
      OP_ADD:   alu_pre = sw1 + sw2;
      OP_SUB:   alu_pre = sw1 - sw2;
      OP_AND:   alu_pre = sw1 & sw2;
      OP_OR:    alu_pre = sw1 | sw2;
      OP_INC:   alu_pre = sw1 + 32'd1;
      OP_DEC:   alu_pre = sw1 - 32'd1;
      default:  alu_pre = sw2;
    endcase
    case (key[1:0])
      SH_NONE: alu_out = alu_pre;
      SH_SL:   alu_out = alu_pre << 1;
      SH_SR:   alu_out = alu_pre >> 1;
      default: alu_out = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one command beat from a negedge; returns at the negedge after acceptance.
  task automatic beat(input logic [31:0] d, input logic [4:0] op);
    bit done = 0;
    in_data  = d;
    in_op    = op;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) begin
        @(posedge clk);
        done = 1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) check("beat_timeout", 0, 1);
  endtask

  // Wait for a result, check it, then let the handshake complete.
  task automatic get_result(input string tag, input logic [31:0] exp_d, input logic [4:0] exp_op);
    bit seen = 0;
    res_ready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (res_valid) seen = 1;
      else @(negedge clk);
    end
    if (!seen) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check({tag, "_data"}, res_data, exp_d);
      check({tag, "_op"}, res_op, exp_op);
      check({tag, "_inrdy"}, in_ready, 0);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_op = '0; in_valid = 1'b0; res_ready = 1'b1;
`ifdef ULA_CHAIN_EN
    in_chain = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_sw1", sw1, 0);
    check("rst_sw2", sw2, 0);
    check("rst_key", key, 0);
    check("rst_res_data", res_data, 0);
    check("rst_op_count", op_count, 0);
    rst = 1'b0;

    // 1: ADD 5+7
    beat(32'd5, 5'b00100);
    beat(32'd7, 5'b11111);
    check("add_exec_inrdy", in_ready, 0);
    check("add_exec_rvalid", res_valid, 0);
    check("add_key", key, 5'b00100);
    @(negedge clk);
    check("add_lat_rvalid", res_valid, 1);
    check("add_sw1", sw1, 5);
    check("add_sw2", sw2, 7);
    get_result("add", 32'd12, 5'b00100);
    check("add_count", op_count, 1);

    // 2: SUB 3-5 then logical shift right
    beat(32'd3, 5'b01010);
    beat(32'd5, 5'b00000);
    get_result("subsr", 32'h7FFF_FFFF, 5'b01010);
    check("subsr_count", op_count, 2);

    // 3: unary INC of all-ones, single beat
    beat(32'hFFFF_FFFF, 5'b10100);
    check("inc_inrdy", in_ready, 0);
    check("inc_sw2", sw2, 0);
    get_result("inc", 32'h0, 5'b10100);
    check("inc_count", op_count, 3);
    check("inc_sw1_hold", sw1, 32'hFFFF_FFFF);

    // 4: result backpressure
    res_ready = 1'b0;
    beat(32'd2, 5'b00100);
    beat(32'd9, 5'b00000);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("bp_rvalid", res_valid, 1);
      check("bp_data", res_data, 11);
      check("bp_inrdy", in_ready, 0);
      check("bp_count", op_count, 3);
      @(negedge clk);
    end
    get_result("bp", 32'd11, 5'b00100);
    check("bp_count_after", op_count, 4);

    // 5: reset after the A beat
    beat(32'd9, 5'b00100);
    check("mid_in_b", in_ready, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_in_ready", in_ready, 1);
    check("mid_sw1", sw1, 0);
    check("mid_key", key, 0);
    check("mid_rvalid", res_valid, 0);
    check("mid_count", op_count, 0);
    @(negedge clk);
    check("mid_stay_idle", res_valid, 0);

    // Unary PASSA with shift left after reset
    beat(32'h4000_0001, 5'b00001);
    get_result("passsl", 32'h8000_0002, 5'b00001);
    check("passsl_count", op_count, 1);

    // DEC with shift-to-zero
    beat(32'd100, 5'b11011);
    get_result("deczero", 32'h0, 5'b11011);

`ifdef ULA_CHAIN_EN
    // 6: accumulate via chaining
    beat(32'd2, 5'b00100);
    beat(32'd3, 5'b00000);
    get_result("chain1", 32'd5, 5'b00100);
    in_chain = 1'b1;
    beat(32'hDEAD_BEEF, 5'b00100);
    in_chain = 1'b0;
    check("chain_sw1", sw1, 5);
    beat(32'd10, 5'b00000);
    get_result("chain2", 32'd15, 5'b00100);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
